// File: rtl/fetch_sequencer.sv
// fetch_sequencer: multicycle fetch controller owning the core's program counter.
// Issues imem requests at pc, latches the returned instruction, hands it to the
// execute stage, then advances or redirects pc. Also handles halt/resume and
// raises a fault when a fetch goes unacknowledged for TIMEOUT cycles.
module fetch_sequencer #(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = 8'h00,
  parameter int                PC_STEP  = 4,
  parameter int                TIMEOUT  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              instr_valid,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              ex_done,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt_req,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              fault,
  output logic [15:0]       retire_count
);

  // Timeout counter only needs to reach TIMEOUT-1; keep at least one bit.
  localparam int TW = ($clog2(TIMEOUT) > 0) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_EXEC   = 3'd2,
    ST_HALTED = 3'd3,
    ST_FAULT  = 3'd4
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;
  logic [31:0]       instr_q;
  logic [ADDR_W-1:0] instr_pc_q;
  logic [15:0]       retire_q;
  logic [15:0]       retire_d;
  logic [TW-1:0]     tcnt_q;
  logic              halt_pending_q;

  // Next pc at retirement (word-aligned redirect or sequential step) and saturating retire count.
  always_comb begin
    pc_d     = pc_q;
    retire_d = retire_q;
    if (redirect) begin
      pc_d = {redirect_pc[ADDR_W-1:2], 2'b00};
    end else begin
      pc_d = pc_q + ADDR_W'(PC_STEP);
    end
    if (retire_q != 16'hFFFF) begin
      retire_d = retire_q + 16'd1;
    end else begin
      retire_d = retire_q;
    end
  end

  // Fetch/execute sequencing FSM with all architectural state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      pc_q           <= RESET_PC;
      instr_q        <= 32'h0000_0000;
      instr_pc_q     <= '0;
      retire_q       <= 16'h0000;
      tcnt_q         <= '0;
      halt_pending_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (run) begin
            state_q <= ST_FETCH;
            tcnt_q  <= '0;
          end
        end
        ST_FETCH: begin
          if (halt_req) begin
            halt_pending_q <= 1'b1;
          end
          // An ack in the last allowed cycle still wins over the timeout.
          if (imem_ack) begin
            instr_q    <= imem_rdata;
            instr_pc_q <= pc_q;
            state_q    <= ST_EXEC;
          end else if (tcnt_q == TCNT_LAST) begin
            state_q <= ST_FAULT;
          end else begin
            tcnt_q <= tcnt_q + TW'(1);
          end
        end
        ST_EXEC: begin
          if (ex_done) begin
            pc_q     <= pc_d;
            retire_q <= retire_d;
            if (halt_pending_q || halt_req) begin
              state_q        <= ST_HALTED;
              halt_pending_q <= 1'b0;
            end else begin
              state_q <= ST_FETCH;
              tcnt_q  <= '0;
            end
          end else if (halt_req) begin
            halt_pending_q <= 1'b1;
          end
        end
        ST_HALTED: begin
          // Resume at the held pc; run takes priority over a concurrent halt_req.
          if (run) begin
            state_q <= ST_FETCH;
            tcnt_q  <= '0;
          end
        end
        ST_FAULT: begin
          state_q <= ST_FAULT;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign imem_req     = (state_q == ST_FETCH);
  assign instr_valid  = (state_q == ST_EXEC);
  assign halted       = (state_q == ST_HALTED);
  assign fault        = (state_q == ST_FAULT);
  assign imem_addr    = pc_q;
  assign pc           = pc_q;
  assign instr        = instr_q;
  assign instr_pc     = instr_pc_q;
  assign retire_count = retire_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: table-driven instruction sequences plus hand-written
// halt, timeout, reset and saturation scenarios; fetched words are checked
// through a scoreboard queue.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0000_0000;
  logic        instr_valid;
  logic [31:0] instr;
  logic [7:0]  instr_pc;
  logic        ex_done = 1'b0;
  logic        redirect = 1'b0;
  logic [7:0]  redirect_pc = 8'h00;
  logic        halt_req = 1'b0;
  logic [7:0]  pc;
  logic        halted;
  logic        fault;
  logic [15:0] retire_count;

  fetch_sequencer dut (
    .clk(clk), .reset(reset), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .ex_done(ex_done), .redirect(redirect), .redirect_pc(redirect_pc),
    .halt_req(halt_req), .pc(pc), .halted(halted), .fault(fault),
    .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    logic [7:0]  addr;
  } exp_t;

  typedef struct {
    int         ack_lat;
    int         exd_lat;
    bit         redir;
    logic [7:0] rpc;
    logic [7:0] ea;
    logic [7:0] en;
  } vec_t;

  exp_t        sbq[$];
  vec_t        tbl[8];
  int          nvec = 0;
  int          nerr = 0;
  logic [15:0] exp_ret = 16'h0000;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pop_chk(input string name);
    exp_t g;
    if (sbq.size() == 0) begin
      nvec++;
      nerr++;
      $display("FAIL %s: scoreboard empty when instr_valid seen", name);
    end else begin
      g = sbq.pop_front();
      chk({name, "_instr"}, instr, g.word);
      chk({name, "_instr_pc"}, {24'h0, instr_pc}, {24'h0, g.addr});
    end
  endtask

  task automatic bump_ret();
    if (exp_ret != 16'hFFFF) exp_ret = exp_ret + 16'd1;
  endtask

  // One full instruction: fetch at ea, ack after ack_lat waits, execute, retire to en.
  task automatic run_instr(input int ack_lat, input int exd_lat, input bit redir,
                           input logic [7:0] rpc, input logic [7:0] ea,
                           input logic [7:0] en, input bit hreq);
    logic [31:0] d;
    chk("req_in_fetch", {31'h0, imem_req}, 32'h1);
    chk("imem_addr", {24'h0, imem_addr}, {24'h0, ea});
    for (int i = 0; i < ack_lat; i++) step();
    d = {16'hC0DE, 8'(ack_lat * 16 + exd_lat), ea};
    imem_ack = 1'b1;
    imem_rdata = d;
    sbq.push_back('{word: d, addr: ea});
    step();
    imem_ack = 1'b0;
    imem_rdata = $urandom;
    chk("instr_valid", {31'h0, instr_valid}, 32'h1);
    pop_chk("exec");
    // Redirect without ex_done must be ignored; instr must stay stable.
    for (int i = 0; i < exd_lat; i++) begin
      redirect = 1'b1;
      redirect_pc = 8'hEC;
      step();
      chk("instr_hold", instr, d);
    end
    redirect = redir;
    redirect_pc = rpc;
    halt_req = hreq;
    ex_done = 1'b1;
    step();
    ex_done = 1'b0;
    redirect = 1'b0;
    halt_req = 1'b0;
    bump_ret();
    chk("next_pc", {24'h0, pc}, {24'h0, en});
    chk("retire_count", {16'h0, retire_count}, {16'h0, exp_ret});
    chk("halted_after", {31'h0, halted}, {31'h0, hreq});
  endtask

  initial begin
    logic [31:0] w;
    tbl[0] = '{ack_lat: 2, exd_lat: 1, redir: 1'b0, rpc: 8'h00, ea: 8'h00, en: 8'h04};
    tbl[1] = '{ack_lat: 2, exd_lat: 1, redir: 1'b0, rpc: 8'h00, ea: 8'h04, en: 8'h08};
    tbl[2] = '{ack_lat: 2, exd_lat: 1, redir: 1'b0, rpc: 8'h00, ea: 8'h08, en: 8'h0C};
    tbl[3] = '{ack_lat: 2, exd_lat: 1, redir: 1'b0, rpc: 8'h00, ea: 8'h0C, en: 8'h10};
    tbl[4] = '{ack_lat: 0, exd_lat: 0, redir: 1'b1, rpc: 8'h37, ea: 8'h10, en: 8'h34};
    tbl[5] = '{ack_lat: 1, exd_lat: 2, redir: 1'b1, rpc: 8'hFE, ea: 8'h34, en: 8'hFC};
    tbl[6] = '{ack_lat: 3, exd_lat: 0, redir: 1'b0, rpc: 8'h00, ea: 8'hFC, en: 8'h00};
    tbl[7] = '{ack_lat: 0, exd_lat: 0, redir: 1'b1, rpc: 8'h20, ea: 8'h00, en: 8'h20};

    // Reset state
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    chk("rst_pc", {24'h0, pc}, 32'h0);
    chk("rst_req", {31'h0, imem_req}, 32'h0);
    chk("rst_valid", {31'h0, instr_valid}, 32'h0);
    chk("rst_flags", {30'h0, halted, fault}, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_retire", {16'h0, retire_count}, 32'h0);

    // halt_req is ignored in IDLE
    halt_req = 1'b1;
    step();
    halt_req = 1'b0;
    chk("idle_halt_ign", {30'h0, halted, imem_req}, 32'h0);

    run = 1'b1;
    step();
    run = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_instr(tbl[i].ack_lat, tbl[i].exd_lat, tbl[i].redir, tbl[i].rpc,
                tbl[i].ea, tbl[i].en, 1'b0);
      if (i == 3) chk("retire_after4", {16'h0, retire_count}, 32'd4);
    end

    // Single-cycle halt pulse during FETCH at 0x20: instruction completes, then halt.
    halt_req = 1'b1;
    step();
    halt_req = 1'b0;
    run_instr(1, 1, 1'b0, 8'h00, 8'h20, 8'h24, 1'b1);
    chk("halt_noreq", {31'h0, imem_req}, 32'h0);
    step();
    step();
    chk("halt_hold", {31'h0, halted}, 32'h1);
    chk("halt_pc_hold", {24'h0, pc}, 32'h24);
    run = 1'b1;
    step();
    run = 1'b0;
    chk("resume_halted", {31'h0, halted}, 32'h0);

    // halt_req coincident with ex_done: pc still updates, then HALTED.
    run_instr(0, 0, 1'b0, 8'h00, 8'h24, 8'h28, 1'b1);

    // run and halt_req together in HALTED: run wins.
    run = 1'b1;
    halt_req = 1'b1;
    step();
    run = 1'b0;
    halt_req = 1'b0;
    chk("run_wins", {31'h0, imem_req}, 32'h1);

    // Timeout: no ack, fault exactly 16 cycles after FETCH entry.
    for (int i = 0; i < 15; i++) step();
    chk("pre_timeout_fault", {31'h0, fault}, 32'h0);
    chk("pre_timeout_req", {31'h0, imem_req}, 32'h1);
    step();
    chk("timeout_fault", {31'h0, fault}, 32'h1);
    chk("timeout_req", {31'h0, imem_req}, 32'h0);
    chk("fault_pc", {24'h0, pc}, 32'h28);
    run = 1'b1;
    step();
    run = 1'b0;
    chk("fault_sticky", {31'h0, fault}, 32'h1);

    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_ret = 16'h0000;
    sbq.delete();
    chk("fault_rst_pc", {24'h0, pc}, 32'h0);
    chk("fault_rst_flags", {29'h0, fault, halted, imem_req}, 32'h0);

    // Ack on the 16th FETCH cycle wins over the timeout.
    run = 1'b1;
    step();
    run = 1'b0;
    for (int i = 0; i < 15; i++) step();
    w = 32'hA5A5_0016;
    imem_ack = 1'b1;
    imem_rdata = w;
    sbq.push_back('{word: w, addr: 8'h00});
    step();
    imem_ack = 1'b0;
    chk("late_ack_valid", {31'h0, instr_valid}, 32'h1);
    chk("late_ack_nofault", {31'h0, fault}, 32'h0);
    pop_chk("late_ack");

    // Reset mid-EXEC at pc 0x40, then a stray ack in IDLE is ignored.
    ex_done = 1'b1;
    redirect = 1'b1;
    redirect_pc = 8'h40;
    step();
    ex_done = 1'b0;
    redirect = 1'b0;
    chk("redir40_addr", {24'h0, imem_addr}, 32'h40);
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_ack = 1'b0;
    chk("exec40_pc", {24'h0, instr_pc}, 32'h40);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst_valid", {31'h0, instr_valid}, 32'h0);
    chk("midrst_pc", {24'h0, pc}, 32'h0);
    chk("midrst_retire", {16'h0, retire_count}, 32'h0);
    imem_ack = 1'b1;
    imem_rdata = 32'h1234_5678;
    step();
    imem_ack = 1'b0;
    chk("stray_ack_valid", {31'h0, instr_valid}, 32'h0);
    chk("stray_ack_instr", instr, 32'h0);
    chk("stray_ack_req", {31'h0, imem_req}, 32'h0);

    // Saturation of retire_count.
    exp_ret = 16'h0000;
    run = 1'b1;
    step();
    run = 1'b0;
    imem_ack = 1'b1;
    imem_rdata = 32'h0000_0013;
    step();
    imem_ack = 1'b0;
    force dut.retire_q = 16'hFFFE;
    #1;
    release dut.retire_q;
    ex_done = 1'b1;
    step();
    ex_done = 1'b0;
    chk("sat_reach", {16'h0, retire_count}, 32'hFFFF);
    exp_ret = 16'hFFFF;
    run_instr(0, 0, 1'b0, 8'h00, 8'h04, 8'h08, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Multicycle fetch controller that owns and sequences the 8-bit program counter of the simple RISC-V core. It issues instruction-memory requests at the current PC and waits for the memory acknowledge. It then presents the fetched instruction to the execute stage and, when execution completes, advances the PC or applies a branch/jump redirect. It also handles halt/resume and flags a fetch timeout fault.

Parameters:
ADDR_W, 8, PC / instruction address width
RESET_PC, 8'h00, PC value loaded on reset
PC_STEP, 4, byte increment per sequential instruction
TIMEOUT, 16, maximum FETCH cycles without imem_ack before FAULT (must be ≥1)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
run  in  1  start from IDLE / resume from HALTED
imem_req  out  1  instruction fetch request; high iff state==FETCH
imem_addr  out  ADDR_W  fetch address; equals pc
imem_ack  in  1  memory has imem_rdata valid this cycle
imem_rdata  in  32  fetched instruction word
instr_valid  out  1  high iff state==EXEC
instr  out  32  latched instruction
instr_pc  out  ADDR_W  PC of latched instruction
ex_done  in  1  execute stage finished current instruction
redirect  in  1  take redirect_pc; sampled only with ex_done
redirect_pc  in  ADDR_W  branch/jump target
halt_req  in  1  request halt at the next instruction boundary
pc  out  ADDR_W  current PC register
halted  out  1  high iff state==HALTED
fault  out  1  high iff state==FAULT
retire_count  out  16  instructions completed, saturating

Behaviour:
- States: IDLE, FETCH, EXEC, HALTED, FAULT. imem_req, instr_valid, halted and fault are decoded from registered state, so there is no combinational path from the inputs.
- Reset values (clk edge with reset=1):
  - state=IDLE, pc=RESET_PC
  - instr=0, instr_pc=0, retire_count=0
  - timeout counter=0, halt_pending=0
  - all flag outputs 0
- Reset overrides every other input and applies in any state, mid-fetch or mid-exec included. An outstanding fetch is abandoned, and an ack arriving afterwards in IDLE is ignored.
- IDLE: run=1 → FETCH. halt_req is ignored.
- FETCH: imem_req=1 and imem_addr=pc. The timeout counter clears on entry and increments each cycle without ack.
  - imem_ack=1 → instr<=imem_rdata, instr_pc<=pc, state→EXEC. Minimum fetch latency is 1 cycle: instr_valid is high the cycle after the ack.
  - No ack and counter==TIMEOUT-1 → FAULT. If ack arrives in that same cycle, the ack wins.
- EXEC: instr_valid=1 and instr is held stable until ex_done.
  - ex_done=1 with redirect=1 → pc<=redirect_pc with bits[1:0] forced to 0.
  - ex_done=1 with redirect=0 → pc<=pc+PC_STEP modulo 2^ADDR_W, so 8'hFC→8'h00.
  - On either ex_done case, retire_count increments, holding at 16'hFFFF.
  - After ex_done, the next state is HALTED if (halt_pending | halt_req), otherwise FETCH. halt_pending clears when entering HALTED.
  - redirect without ex_done is ignored.
- halt_req asserted in FETCH or EXEC sets halt_pending, even if it is a single-cycle pulse. It takes effect only at the next ex_done, so an in-flight instruction always completes.
- HALTED: pc is held. run=1 → FETCH at the held pc (resume, no reset of pc). If halt_req and run are both high, run wins.
- FAULT: all requests are deasserted and pc is frozen. Only reset exits FAULT.
- EXEC with simultaneous ex_done and halt_req: the PC update still occurs, then the state goes to HALTED.

Test Plan:
- Sequential fetch: reset, run pulse, memory acks after 2 cycles, ex_done 1 cycle after instr_valid → imem_addr sequence 00,04,08,0C. instr_pc matches each address. retire_count=4 after four instructions.
- Redirect and wrap: in EXEC at pc=8'h10, ex_done with redirect_pc=8'h37 → next imem_addr=8'h34. Separately, pc=8'hFC with ex_done and no redirect → next pc=8'h00.
- Halt/resume: 1-cycle halt_req pulse during FETCH at pc=8'h20 → instruction at 20 completes, halted=1, pc=8'h24, no imem_req. run pulse → FETCH at 8'h24.
- Timeout: TIMEOUT=16, no ack → fault=1 exactly 16 cycles after FETCH entry and imem_req drops. Ack on cycle 16 instead → EXEC, no fault. Reset → IDLE, pc=0.
- Reset mid-operation: assert reset during EXEC at pc=8'h40 → next cycle state IDLE, pc=RESET_PC, instr_valid=0, retire_count=0. A late imem_ack is ignored.
- Saturation: preload retire_count near 16'hFFFF via a long run (or a bench force) → it holds at 16'hFFFF.
